// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MIN   = 2;
    localparam int NUM_REQ_MAX   = 16;
    localparam int MAX_BURST_MIN = 1;

    // max(1, $clog2(max_burst)); keeps a 1-bit counter for MAX_BURST of 1 or 2
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst <= 2) ? 1 : $clog2(max_burst);
    endfunction

    function automatic bit params_legal(input int num_req, input int max_burst);
        return (num_req >= NUM_REQ_MIN) && (num_req <= NUM_REQ_MAX) &&
               (max_burst >= MAX_BURST_MIN);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_i, wrapping around; last_i itself is considered last.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] pick_oh_o,
    output logic [IDX_W-1:0]   pick_idx_o,
    output logic               valid_o
);

    int                 sum;
    logic [IDX_W-1:0]   cand;

    always_comb begin
        pick_oh_o  = '0;
        pick_idx_o = '0;
        valid_o    = 1'b0;
        sum        = 0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(last_i) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IDX_W'(sum);
            if (!valid_o && req_i[cand]) begin
                valid_o         = 1'b1;
                pick_idx_o      = cand;
                pick_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// producers; each grant passes through IDLE, so handoffs cost one bubble.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam int                CNT_W     = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BURST - 1);
    localparam bit                PARAMS_OK = params_legal(NUM_REQ, MAX_BURST);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q,  last_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                in_burst;
    logic                owner_req;
    logic                accept;

    always_comb begin : p_param_chk
        assert (PARAMS_OK);
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i      (req),
        .last_i     (last_q),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

    assign in_burst  = (state_q == BURST);
    assign owner_req = req[owner_q];
    assign accept    = in_burst & owner_req & ~fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    grant_d = pick_oh;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                // A dropped request forfeits the grant; a full FIFO simply stalls.
                if (!owner_req || (accept && (cnt_q == CNT_LAST))) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        ack = '0;
        if (accept) ack[owner_q] = 1'b1;
    end

    assign grant        = grant_q;
    assign fifo_cs      = in_burst;
    assign busy         = in_burst;
    assign fifo_wr_en   = accept;
    assign fifo_data_in = in_burst ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH]
                                   : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle comparison against a
// behavioural model plus hand-computed scenario expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic              fifo_full = 1'b0;
    logic [N-1:0]      ack, grant;
    logic              fifo_cs, fifo_wr_en, busy;
    logic [DW-1:0]     fifo_data_in;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .grant        (grant),
        .fifo_full    (fifo_full),
        .fifo_cs      (fifo_cs),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy;
    int m_owner, m_cnt, m_last, m_words;

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    function automatic bit exp_accept();
        return m_busy && req[m_owner] && !fifo_full;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_owner <= 0; m_cnt <= 0; m_last <= N - 1; m_words <= 0;
        end else if (!m_busy) begin
            if (rr_next(req, m_last) >= 0) begin
                m_busy <= 1'b1; m_owner <= rr_next(req, m_last); m_cnt <= 0;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0; m_last <= m_owner;
        end else if (!fifo_full) begin
            m_words <= m_words + 1;
            if (m_cnt == MB - 1) begin
                m_busy <= 1'b0; m_last <= m_owner; m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_grant", 64'(grant), 64'(m_busy ? onehot(m_owner) : '0));
        chk("cmp_ack", 64'(ack), 64'(exp_accept() ? onehot(m_owner) : '0));
        chk("cmp_wr_en", 64'(fifo_wr_en), 64'(exp_accept()));
        chk("cmp_cs", 64'(fifo_cs), 64'(m_busy));
        chk("cmp_busy", 64'(busy), 64'(m_busy));
        chk("cmp_data", 64'(fifo_data_in), 64'(m_busy ? req_data[m_owner*DW +: DW] : '0));
    end

    // ---------------- trace helpers ----------------
    logic [N-1:0]  tg[$], ta[$];
    logic          tw[$];
    logic [DW-1:0] td[$];

    task automatic clr();
        tg.delete(); ta.delete(); tw.delete(); td.delete();
    endtask

    task automatic cyc();
        @(negedge clk);
        tg.push_back(grant); ta.push_back(ack); tw.push_back(fifo_wr_en); td.push_back(fifo_data_in);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; fifo_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic setd(input int p, input logic [DW-1:0] v);
        req_data[p*DW +: DW] = v;
    endtask

    function automatic int nwr(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (tw[c]) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] fq[$], rout[$];
        int            order[$];
        int            sent[3];
        int            wj, maxsz, cnum;
        logic          s_wr;
        logic [N-1:0]  s_ack;
        logic [DW-1:0] s_dat;

        // reset state
        rst_n = 1'b0;
        #2;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // single producer 2, full burst, bubble, re-grant
        do_reset(); clr();
        req = 4'b0100; setd(2, 32'hC0DE_0002);
        for (int c = 0; c < 7; c++) cyc();
        chk("t1_grant_c0", 64'(tg[0]), 64'h0);
        chk("t1_grant_c1", 64'(tg[1]), 64'b0100);
        chk("t1_ack_c1", 64'(ta[1]), 64'b0100);
        chk("t1_writes", 64'(nwr(0, 5)), 64'd4);
        for (int c = 1; c <= 4; c++) chk("t1_data", 64'(td[c]), 64'hC0DE_0002);
        chk("t1_bubble", 64'(tg[5]), 64'h0);
        chk("t1_regrant", 64'(tg[6]), 64'b0100);
        chk("t1_model_owner", 64'(m_owner), 64'd2);
        req = '0; cyc();

        // all four requesting: fairness and duty
        do_reset(); clr();
        req = 4'b1111;
        for (int p = 0; p < N; p++) setd(p, 32'hA000_0000 + DW'(p));
        for (int c = 0; c < 25; c++) cyc();
        order.delete();
        for (int c = 1; c < 25; c++)
            if (tg[c] != '0 && tg[c-1] == '0) order.push_back($clog2(tg[c]));
        chk("t2_ngrants", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("t2_order", 64'(order[i]), 64'(i % 4));
        chk("t2_writes", 64'(nwr(0, 24)), 64'd20);
        for (int w = 0; w < 4; w++) chk("t2_duty", 64'(nwr(5*w + 1, 5*w + 5)), 64'd4);
        wj = 0;
        for (int c = 0; c < 25; c++)
            if (tw[c]) begin
                chk("t2_data", 64'(td[c]), 64'(32'hA000_0000 + DW'((wj / 4) % 4)));
                wj++;
            end

        // producer 1 stalled by full for 3 cycles after its 2nd write
        do_reset(); clr();
        req = 4'b0010; setd(1, 32'hB000_0001);
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            cyc();
        end
        fifo_full = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            chk("t3_stall_wr", 64'(tw[c]), 64'h0);
            chk("t3_stall_ack", 64'(ta[c]), 64'h0);
            chk("t3_stall_grant", 64'(tg[c]), 64'b0010);
        end
        chk("t3_wr_c6", 64'(tw[6]), 64'h1);
        chk("t3_wr_c7", 64'(tw[7]), 64'h1);
        chk("t3_writes", 64'(nwr(0, 8)), 64'd4);
        chk("t3_idle_c8", 64'(tg[8]), 64'h0);
        req = '0; cyc();

        // producer 3 drops after one write; wrap-around to 0
        do_reset(); clr();
        req = 4'b1000; setd(3, 32'hD000_0003); setd(0, 32'hD000_0000);
        cyc(); cyc();
        req = 4'b0001; cyc();
        req = 4'b1001; cyc(); cyc();
        chk("t4_grant_c1", 64'(tg[1]), 64'b1000);
        chk("t4_wr_c1", 64'(tw[1]), 64'h1);
        chk("t4_drop_wr", 64'(tw[2]), 64'h0);
        chk("t4_drop_ack", 64'(ta[2]), 64'h0);
        chk("t4_idle_c3", 64'(tg[3]), 64'h0);
        chk("t4_wrap_grant", 64'(tg[4]), 64'b0001);
        chk("t4_wrap_data", 64'(td[4]), 64'hD000_0000);
        chk("t4_model_owner", 64'(m_owner), 64'd0);
        req = '0; cyc();

        // reset mid-burst (owner 2, two words written)
        do_reset(); clr();
        req = 4'b0100; setd(2, 32'hC0DE_0002);
        cyc(); cyc(); cyc();
        #2;
        chk("t5_pre_wr", 64'(fifo_wr_en), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_wr", 64'(fifo_wr_en), 64'h0);
        chk("t5_rst_ack", 64'(ack), 64'h0);
        chk("t5_rst_grant", 64'(grant), 64'h0);
        chk("t5_rst_data", 64'(fifo_data_in), 64'h0);
        req = 4'b0110; setd(1, 32'h5000_0001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr(); cyc(); cyc();
        chk("t5_after_grant", 64'(tg[1]), 64'b0010);
        req = '0; cyc();

        // end-to-end through a depth-8 FIFO model, reads begin late
        do_reset();
        fq.delete(); rout.delete(); order.delete();
        sent = '{0, 0, 0}; maxsz = 0; cnum = 0;
        while (rout.size() < 12 && cnum < 400) begin
            req = '0;
            for (int p = 0; p < 3; p++) begin
                req[p] = (sent[p] < 4);
                setd(p, 32'hE000_0000 | DW'(p << 8) | DW'(sent[p] & 3));
            end
            fifo_full = (fq.size() >= 8);
            @(negedge clk);
            s_wr = fifo_wr_en; s_ack = ack; s_dat = fifo_data_in;
            if (s_wr) chk("t6_no_overflow", 64'(fq.size() < 8), 64'h1);
            if (s_wr && (order.size() == 0 || order[order.size()-1] != $clog2(grant)))
                order.push_back($clog2(grant));
            @(posedge clk);
            if (cnum >= 10 && cnum % 2 == 0 && fq.size() > 0) rout.push_back(fq.pop_front());
            if (s_wr) fq.push_back(s_dat);
            for (int p = 0; p < 3; p++) if (s_ack[p]) sent[p]++;
            if (fq.size() > maxsz) maxsz = fq.size();
            cnum++;
            #1;
        end
        fifo_full = 1'b0; req = '0;
        chk("t6_readout_count", 64'(rout.size()), 64'd12);
        chk("t6_hit_full", 64'(maxsz), 64'd8);
        chk("t6_grant_runs", 64'(order.size()), 64'd3);
        for (int i = 0; i < order.size() && i < 3; i++) chk("t6_grant_order", 64'(order[i]), 64'(i));
        for (int j = 0; j < rout.size(); j++)
            chk("t6_readout", 64'(rout[j]), 64'(32'hE000_0000 | DW'((j / 4) << 8) | DW'(j % 4)));
        chk("t6_model_words", 64'(m_words), 64'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
